// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter. It merges the pipeline WB stage with a
// small result buffer fed by the long-latency (mul/div) unit. The pipeline
// wins by default. After STARVE_LIMIT consecutive pipeline wins against a
// non-empty buffer, the pipeline is stalled for one cycle so that the buffer
// head can drain. The write port is registered, so a grant appears on
// RegWrite one cycle later.
module reg_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        RegWrite,
    output logic [4:0]  Write_Reg,
    output logic [31:0] WB_result,
    output logic        stall_pipe,
    output logic [31:0] pending_mask,
    output logic        err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    // buffer storage and bookkeeping
    logic [4:0]            rd_mem_q   [FIFO_DEPTH];
    logic [4:0]            rd_mem_d   [FIFO_DEPTH];
    logic [31:0]           data_mem_q [FIFO_DEPTH];
    logic [31:0]           data_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // arbitration and output state
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  regwrite_q, regwrite_d;
    logic [4:0]            write_reg_q, write_reg_d;
    logic [31:0]           wb_result_q, wb_result_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pipe_req;
    logic                  grant_pipe;
    logic                  grant_fifo;
    logic                  lu_push;
    logic [31:0]           pending_mask_c;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Writes to x0 are meaningless, so they never compete for the port.
    assign pipe_req   = pipe_we & (pipe_rd != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // The stall depends only on registered state, so the pipeline can act on it
    // within the same cycle without a combinational loop through pipe_we.
    assign stall_pipe = (starve_q == STV_MAX) & ~fifo_empty;
    assign grant_pipe = pipe_req & ~stall_pipe;
    assign grant_fifo = ~grant_pipe & ~fifo_empty;

    // Ready is based on the current occupancy only. A pop in the same cycle does
    // not give credit, which keeps lu_ready off the arbitration path.
    // ready_q holds it low during reset and for the rest of that cycle.
    assign lu_ready   = ready_q & ~fifo_full;
    assign lu_push    = lu_valid & lu_ready & (lu_rd != 5'd0);

    // buffer next state: enqueue at the tail, pop the head when it is granted
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        slot_vld_d = slot_vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (lu_push) begin
            rd_mem_d[wr_ptr_q]   = lu_rd;
            data_mem_d[wr_ptr_q] = lu_data;
            slot_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end
        if (grant_fifo) begin
            slot_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = ptr_next(rd_ptr_q);
        end
        case ({lu_push, grant_fifo})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // starvation counter: counts pipeline wins over a waiting buffer, saturating
    always_comb begin
        starve_d = starve_q;
        if (grant_fifo || fifo_empty) begin
            starve_d = '0;
        end else if (grant_pipe && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // write-port register next state; the address and data hold when nothing is granted
    always_comb begin
        regwrite_d  = grant_pipe | grant_fifo;
        write_reg_d = write_reg_q;
        wb_result_d = wb_result_q;
        if (grant_pipe) begin
            write_reg_d = pipe_rd;
            wb_result_d = pipe_data;
        end else if (grant_fifo) begin
            write_reg_d = rd_mem_q[rd_ptr_q];
            wb_result_d = data_mem_q[rd_ptr_q];
        end
        err_d   = err_q | (stall_pipe & pipe_req);
        ready_d = 1'b1;
    end

    // registers targeted by buffered results, for the pipeline's hazard check
    always_comb begin
        pending_mask_c = '0;
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            if (slot_vld_q[s]) begin
                pending_mask_c[rd_mem_q[s]] = 1'b1;
            end
        end
    end

    // all state: reset discards buffered entries and any write not yet presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < FIFO_DEPTH; s++) begin
                rd_mem_q[s]   <= '0;
                data_mem_q[s] <= '0;
            end
            slot_vld_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            regwrite_q  <= 1'b0;
            write_reg_q <= '0;
            wb_result_q <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            rd_mem_q    <= rd_mem_d;
            data_mem_q  <= data_mem_d;
            slot_vld_q  <= slot_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            regwrite_q  <= regwrite_d;
            write_reg_q <= write_reg_d;
            wb_result_q <= wb_result_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign RegWrite     = regwrite_q;
    assign Write_Reg    = write_reg_q;
    assign WB_result    = wb_result_q;
    assign err          = err_q;
    assign pending_mask = pending_mask_c;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter. The driver keeps a behavioural model
// of the buffer as a queue and pushes each expected register-file write,
// tagged with its due cycle. A separate monitor pops and compares whenever
// RegWrite is seen.
module tb_reg_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        RegWrite;
    logic [4:0]  Write_Reg;
    logic [31:0] WB_result;
    logic        stall_pipe;
    logic [31:0] pending_mask;
    logic        err;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .RegWrite     (RegWrite),
        .Write_Reg    (Write_Reg),
        .WB_result    (WB_result),
        .stall_pipe   (stall_pipe),
        .pending_mask (pending_mask),
        .err          (err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    ent_t        fifo_m[$];
    int          starve_m = 0;
    bit          err_m = 1'b0;
    bit          lu_pend = 1'b0;
    logic [4:0]  lu_p_rd = '0;
    logic [31:0] lu_p_data = '0;
    logic [4:0]  last_rd = '0;
    logic [31:0] last_data = '0;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // monitor: every presented write must match the next expected one, on time
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            last_rd   = '0;
            last_data = '0;
        end else if (RegWrite) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got rd %0d data %0h expected no write at cycle %0d",
                         Write_Reg, WB_result, cyc);
                last_rd   = Write_Reg;
                last_data = WB_result;
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_rd", 32'(Write_Reg), 32'(mon_e.rd));
                chk("wr_data", WB_result, mon_e.data);
                chk("wr_cycle", 32'(cyc), 32'(mon_e.due));
                last_rd   = mon_e.rd;
                last_data = mon_e.data;
            end
        end else begin
            chk("hold_rd", 32'(Write_Reg), 32'(last_rd));
            chk("hold_data", WB_result, last_data);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_write: got RegWrite 0 expected rd %0d data %0h at cycle %0d",
                         exp_q[0].rd, exp_q[0].data, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // one cycle: check state-derived outputs, drive inputs, advance the model
    task automatic step(input logic pwe_i, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv_i, input logic [4:0] lrd_i, input logic [31:0] ld_i,
                        input bit respect);
        bit          e_ready, e_stall, preq, gp, gf, lv, pwe;
        logic [31:0] e_mask;
        logic [4:0]  lrd;
        logic [31:0] ld;
        int          occ;
        ent_t        h;
        @(negedge clk);
        occ     = fifo_m.size();
        e_ready = (occ < DEPTH);
        e_stall = (starve_m == LIMIT) && (occ > 0);
        e_mask  = '0;
        foreach (fifo_m[i]) e_mask[fifo_m[i].rd] = 1'b1;
        chk("lu_ready", 32'(lu_ready), 32'(e_ready));
        chk("stall_pipe", 32'(stall_pipe), 32'(e_stall));
        chk("pending_mask", pending_mask, e_mask);
        chk("err", 32'(err), 32'(err_m));

        lv  = lv_i;
        lrd = lrd_i;
        ld  = ld_i;
        if (lu_pend) begin
            lv  = 1'b1;
            lrd = lu_p_rd;
            ld  = lu_p_data;
        end
        pwe = pwe_i;
        if (respect && e_stall) pwe = 1'b0;
        pipe_we   = pwe;
        pipe_rd   = prd;
        pipe_data = pd;
        lu_valid  = lv;
        lu_rd     = lrd;
        lu_data   = ld;

        preq = pwe && (prd != 5'd0);
        gp   = !e_stall && preq;
        gf   = !gp && (occ > 0);
        if (gp) begin
            exp_q.push_back('{prd, pd, cyc + 1});
        end else if (gf) begin
            h = fifo_m.pop_front();
            exp_q.push_back('{h.rd, h.data, cyc + 1});
        end
        if (gf || occ == 0) starve_m = 0;
        else if (gp && starve_m < LIMIT) starve_m++;
        if (e_stall && preq) err_m = 1'b1;
        if (lv && e_ready && lrd != 5'd0) fifo_m.push_back('{lrd, ld});
        lu_pend   = lv && !e_ready;
        lu_p_rd   = lrd;
        lu_p_data = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b0;
        pipe_we  = 1'b0;
        pipe_rd  = '0;
        lu_valid = 1'b0;
        lu_rd    = '0;
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_Write_Reg", 32'(Write_Reg), 32'd0);
        chk("rst_WB_result", WB_result, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        chk("rst_stall", 32'(stall_pipe), 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        exp_q.delete();
        fifo_m.delete();
        starve_m = 0;
        err_m    = 1'b0;
        lu_pend  = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_hold_lu_ready", 32'(lu_ready), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r_prd, r_lrd;
        logic        r_pwe, r_lv;
        logic [31:0] r_pd, r_ld;
        bit          r_resp;

        do_reset(3);

        // pipe only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(2);

        // lu only
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b1);
        idle(3);

        // fill the buffer under continuous pipe traffic; third lu transfer waits
        step(1'b1, 5'd9, 32'h100, 1'b1, 5'd11, 32'hA11, 1'b1);
        step(1'b1, 5'd10, 32'h101, 1'b1, 5'd12, 32'hA12, 1'b1);
        step(1'b1, 5'd9, 32'h102, 1'b1, 5'd13, 32'hA13, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 5'd9, 32'h103 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
        idle(4);

        // x0 targets from both sources
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b1);
        step(1'b1, 5'd0, 32'h56, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(2);

        // starvation with the pipeline ignoring the stall (sets err)
        step(1'b1, 5'd9, 32'h200, 1'b1, 5'd3, 32'h333, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 5'd9, 32'h201 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
        idle(3);

        // reset with two buffered entries
        step(1'b1, 5'd20, 32'h300, 1'b1, 5'd21, 32'h321, 1'b1);
        step(1'b1, 5'd20, 32'h301, 1'b1, 5'd22, 32'h322, 1'b1);
        do_reset(2);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1);
            r_pwe  = ($urandom_range(0, 2) != 0);
            r_prd  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) r_prd = 5'd0;
            r_pd   = $urandom;
            r_lv   = ($urandom_range(0, 4) < 2);
            r_lrd  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) r_lrd = 5'd0;
            r_ld   = $urandom;
            r_resp = ($urandom_range(0, 19) != 0);
            step(r_pwe, r_prd, r_pd, r_lv, r_lrd, r_ld, r_resp);
        end
        idle(8);
        chk("drain_expected", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
